// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable: loadable instruction memory for the IF stage.
// One registered fetch per cycle with stall/flush from the hazard unit.
// The debug unit streams a new program in through a RUN/LOAD state machine,
// and fetch returns NOP while a load is in progress.
// Optional feature macro: IMEM_BYTE_ADDR_EN (inAddr is a byte address).
// When it is not defined, inAddr is a word address.
module instr_mem_loadable #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       inAddr,
   input  logic              stall,
   input  logic              flush,
   output logic [DATA_W-1:0] outData,
   output logic              addr_err,
   input  logic              dbg_start,
   input  logic              wr_instruction,
   input  logic [DATA_W-1:0] data_instruction,
   input  logic              dbg_done,
   output logic [CNT_W-1:0]  load_count,
   output logic              load_full,
   output logic              ready
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0]      DEPTH_A = 32'(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [0:0] {
      S_RUN  = 1'b0,
      S_LOAD = 1'b1
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              load_clear;
   logic              do_write;
   logic              set_full;
   logic [IDX_W-1:0]  wr_idx;

   logic [31:0]       fetch_word;
   logic              fetch_in_range;
   logic [IDX_W-1:0]  rd_idx;

   // Word index and range check for the fetch address; the full value is
   // compared so large addresses can never alias onto a valid word.
`ifdef IMEM_BYTE_ADDR_EN
   assign fetch_word     = {2'b00, inAddr[31:2]};
   assign fetch_in_range = (inAddr[1:0] == 2'b00) && (fetch_word < DEPTH_A);
`else
   assign fetch_word     = inAddr;
   assign fetch_in_range = (fetch_word < DEPTH_A);
`endif

   assign rd_idx = fetch_word[IDX_W-1:0];
   assign wr_idx = load_count[IDX_W-1:0];
   assign ready  = (state == S_RUN);

   // Load state machine: next state plus the write/clear/full controls.
   always_comb begin
      state_nxt  = state;
      load_clear = 1'b0;
      do_write   = 1'b0;
      set_full   = 1'b0;
      unique case (state)
         S_RUN: begin
            if (dbg_start) begin
               state_nxt  = S_LOAD;
               load_clear = 1'b1;
            end
         end
         S_LOAD: begin
            if (dbg_start) begin
               load_clear = 1'b1;
            end else begin
               if (wr_instruction) begin
                  if (load_count < DEPTH_C) begin
                     do_write = 1'b1;
                  end else begin
                     set_full = 1'b1;
                  end
               end
               if (dbg_done) begin
                  state_nxt = S_RUN;
               end
            end
         end
         default: begin
            state_nxt = S_RUN;
         end
      endcase
   end

   // State register; reset always returns to RUN, even mid-load.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // Load pointer and sticky overflow flag; the pointer saturates at DEPTH.
   always_ff @(posedge clk) begin
      if (!rst) begin
         load_count <= '0;
         load_full  <= 1'b0;
      end else if (load_clear) begin
         load_count <= '0;
         load_full  <= 1'b0;
      end else begin
         if (do_write) begin
            load_count <= load_count + CNT_W'(1);
         end
         if (set_full) begin
            load_full <= 1'b1;
         end
      end
   end

   // Array write port; contents survive reset so a partial load is kept.
   always_ff @(posedge clk) begin
      if (rst && do_write) begin
         mem[wr_idx] <= data_instruction;
      end
   end

   // Registered fetch port: LOAD/flush give NOP, stall holds, else read.
   always_ff @(posedge clk) begin
      if (!rst) begin
         outData  <= '0;
         addr_err <= 1'b0;
      end else if ((state == S_LOAD) || flush) begin
         outData  <= '0;
         addr_err <= 1'b0;
      end else if (stall) begin
         outData  <= outData;
         addr_err <= addr_err;
      end else if (fetch_in_range) begin
         outData  <= mem[rd_idx];
         addr_err <= 1'b0;
      end else begin
         outData  <= '0;
         addr_err <= 1'b1;
      end
   end

endmodule
